// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache, one word per line.
// Hits complete combinationally; misses run a WRITEBACK/ALLOCATE FSM against main memory.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       core_addr,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              DC_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      addr_tag;
  logic                  access;
  logic                  hit;
  logic                  store_hit;
  logic                  fill;
  logic                  unused_addr_lsb;

  assign idx             = core_addr[INDEX_BITS+1:2];
  assign addr_tag        = core_addr[31:INDEX_BITS+2];
  assign unused_addr_lsb = ^core_addr[1:0];

  always_comb begin
    access    = core_re | core_we;
    hit       = access & valid[idx] & (tag_mem[idx] == addr_tag);
    store_hit = (state == IDLE) & hit & core_we;
    fill      = (state == ALLOCATE) & mem_ready;
    DC_stall  = (state != IDLE) | (access & ~hit);
    core_rdata = '0;
    if ((state == IDLE) && hit && core_re && !core_we)
      core_rdata = data_mem[idx];
  end

  // Tag/data are deliberately unreset; a fill cut short by rst is dropped via valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) begin
        data_mem[idx] <= core_wdata;
      end else if (fill) begin
        data_mem[idx] <= mem_rdata;
        tag_mem[idx]  <= addr_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (store_hit) begin
            dirty[idx] <= 1'b1;
          end else if (access && !hit) begin
            mem_req <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[idx], idx, 2'b00};
              mem_wdata <= data_mem[idx];
            end else begin
              state    <= ALLOCATE;
              mem_we   <= 1'b0;
              mem_addr <= {core_addr[31:2], 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            dirty[idx] <= 1'b0;
            state      <= ALLOCATE;
            mem_we     <= 1'b0;
            mem_addr   <= {core_addr[31:2], 2'b00};
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            mem_req    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: golden memory view plus line-presence model for miss cost,
// a 3-cycle memory responder, and directed literal checks.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] core_addr = '0;
  logic        core_re = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        DC_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl #(.INDEX_BITS(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_re(core_re), .core_we(core_we),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .DC_stall(DC_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Physical memory and the architecturally visible (golden) memory.
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] golden [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hAAAA0001;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (golden.exists(wa)) return golden[wa];
    return mem_rd(wa);
  endfunction

  // Which address occupies each line, and whether it is modified.
  bit          m_valid [64];
  bit          m_dirty [64];
  logic [23:0] m_tag   [64];

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    golden.delete();
  endfunction

  function automatic int model_access(input logic [31:0] a, input logic we);
    int          i;
    int          cost;
    logic [23:0] t;
    i = int'(a[7:2]);
    t = a[31:8];
    if (m_valid[i] && m_tag[i] == t) begin
      if (we) m_dirty[i] = 1'b1;
      return 0;
    end
    cost = 1 + 3 + ((m_valid[i] && m_dirty[i]) ? 3 : 0);
    m_valid[i] = 1'b1;
    m_tag[i]   = t;
    m_dirty[i] = we;
    return cost;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t log_q[$];

  // Memory responder: mem_ready in the 3rd cycle of each transaction.
  int          cnt = 0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic        t_we = 1'b0;

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      cnt = 0;
      mem_ready = 1'b0;
    end else begin
      if (mem_ready) cnt = 0;
      cnt++;
      if (cnt == 1) begin
        t_addr  = mem_addr;
        t_we    = mem_we;
        t_wdata = mem_wdata;
        log_q.push_back('{mem_we, mem_addr, mem_wdata});
      end else begin
        check("mem_addr_stable", mem_addr, t_addr);
        check("mem_we_stable", 32'(mem_we), 32'(t_we));
        if (t_we) check("mem_wdata_stable", mem_wdata, t_wdata);
      end
      mem_ready = (cnt == 3);
      mem_rdata = t_we ? 32'h0 : mem_rd(mem_addr);
      if (mem_ready && mem_we) begin
        check("wb_data", mem_wdata, gold_rd(mem_addr));
        mem[mem_addr] = mem_wdata;
      end
    end
  end

  // Every-cycle compare against the golden memory view.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_re && !core_we && !DC_stall)
        check("load_data", core_rdata, gold_rd(core_addr));
      if (core_we && !DC_stall)
        golden[{core_addr[31:2], 2'b00}] = core_wdata;
      if (!core_re && !core_we) begin
        check("idle_stall", 32'(DC_stall), 32'h0);
        check("idle_mem_req", 32'(mem_req), 32'h0);
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic re, input logic we,
                        input logic [31:0] wd, input int lit_stall, input string name,
                        output logic [31:0] rd);
    int n;
    int exp;
    n   = 0;
    exp = model_access(a, we);
    core_addr  = a;
    core_re    = re;
    core_we    = we;
    core_wdata = wd;
    @(negedge clk);
    while (DC_stall && n < 30) begin
      n++;
      @(negedge clk);
    end
    rd = core_rdata;
    check({name, "_stall_model"}, n, exp);
    check({name, "_stall"}, n, lit_stall);
    @(posedge clk); #1;
    core_re = 1'b0;
    core_we = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_stall", 32'(DC_stall), 32'h0);
    @(posedge clk); #1;

    // Cold load miss
    log_q.delete();
    access(32'h100, 1'b1, 1'b0, 32'h0, 4, "t1", rd);
    check("t1_rdata", rd, 32'hAAAA0001);
    check("t1_ntxn", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("t1_addr", log_q[0].addr, 32'h100);
      check("t1_we", 32'(log_q[0].we), 32'h0);
    end

    // Load hit
    log_q.delete();
    access(32'h100, 1'b1, 1'b0, 32'h0, 0, "t2", rd);
    check("t2_rdata", rd, 32'hAAAA0001);
    check("t2_ntxn", log_q.size(), 0);

    // Store hit then dirty eviction
    access(32'h100, 1'b0, 1'b1, 32'h12345678, 0, "t3s", rd);
    log_q.delete();
    access(32'h200, 1'b1, 1'b0, 32'h0, 7, "t3l", rd);
    check("t3_rdata", rd, 32'hC0DE0200);
    check("t3_ntxn", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("t3_wb_we", 32'(log_q[0].we), 32'h1);
      check("t3_wb_addr", log_q[0].addr, 32'h100);
      check("t3_wb_data", log_q[0].wdata, 32'h12345678);
      check("t3_al_we", 32'(log_q[1].we), 32'h0);
      check("t3_al_addr", log_q[1].addr, 32'h200);
    end

    // Store miss, then eviction through 0x404
    log_q.delete();
    access(32'h304, 1'b0, 1'b1, 32'hDEADBEEF, 4, "t4s", rd);
    check("t4s_ntxn", log_q.size(), 1);
    if (log_q.size() >= 1) check("t4s_addr", log_q[0].addr, 32'h304);
    log_q.delete();
    access(32'h404, 1'b1, 1'b0, 32'h0, 7, "t4l", rd);
    if (log_q.size() >= 1) begin
      check("t4_wb_we", 32'(log_q[0].we), 32'h1);
      check("t4_wb_addr", log_q[0].addr, 32'h304);
      check("t4_wb_data", log_q[0].wdata, 32'hDEADBEEF);
    end else begin
      check("t4_ntxn", log_q.size(), 2);
    end

    // Reset during the 2nd ALLOCATE cycle of a load of 0x100
    core_addr = 32'h100;
    core_re   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst     = 1'b1;
    core_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("t5_mem_req", 32'(mem_req), 32'h0);
    check("t5_stall", 32'(DC_stall), 32'h0);
    @(posedge clk); #1;
    log_q.delete();
    access(32'h100, 1'b1, 1'b0, 32'h0, 4, "t5", rd);
    check("t5_rdata", rd, 32'h12345678);
    if (log_q.size() >= 1) check("t5_addr", log_q[0].addr, 32'h100);

    // re and we together: store wins
    access(32'h8, 1'b1, 1'b1, 32'h5, 4, "t6s", rd);
    access(32'h8, 1'b1, 1'b0, 32'h0, 0, "t6l", rd);
    check("t6_rdata", rd, 32'h5);

    // Back-to-back hits without a bubble
    core_addr = 32'h8;
    core_re   = 1'b1;
    @(negedge clk);
    check("t7a_stall", 32'(DC_stall), 32'h0);
    check("t7a_rdata", core_rdata, 32'h5);
    @(posedge clk); #1;
    core_addr = 32'h100;
    @(negedge clk);
    check("t7b_stall", 32'(DC_stall), 32'h0);
    check("t7b_rdata", core_rdata, 32'h12345678);
    @(posedge clk); #1;
    core_re = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
